fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning instruction buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-007 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-008 SHALL have port imem_rsp_valid  input  1  in-order response valid; no backpressure.
REQ-009 SHALL have port imem_rsp_data  input  32  fetched instruction.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump redirect.
REQ-011 SHALL have port redirect_pc  input  32  redirect target.
REQ-012 SHALL have port id_valid  output  1  instruction available to decode.
REQ-013 SHALL have port id_ready  input  1  decode accepts instruction.
REQ-014 SHALL have port id_instr, id_pc  output  32 each  instruction and its address.
REQ-015 SHALL have port id_opcode  output  7  id_instr[6:0], feeds the control unit opcode input.
REQ-016 SHALL have port id_illegal  output  1  opcode not recognised (see REQ-033).

Function
REQ-017 SHALL hold a PC register; request accepted (valid && ready) SHALL advance PC by 4, wrapping 32'hFFFF_FFFC -> 0.
REQ-018 SHALL assert imem_req_valid only when outstanding + fifo_count < FIFO_DEPTH and redirect_valid == 0.
REQ-019 imem_req_addr SHALL equal PC and stay stable while valid && !ready, except on redirect (REQ-022).
REQ-020 Outstanding counter SHALL +1 on accepted request, -1 on imem_rsp_valid; both same cycle -> unchanged.
REQ-021 Non-dropped response SHALL push {data, pc} into FIFO; id_valid SHALL rise the cycle after the push (1-cycle rsp-to-decode latency).
REQ-022 On redirect_valid: PC <= {redirect_pc[31:2], 2'b00}, FIFO flushed, imem_req_valid withdrawn that cycle; imem_req_addr = redirect target in the next cycle.
REQ-023 On redirect, drop_cnt SHALL load outstanding minus any response arriving that cycle; responses while drop_cnt != 0 SHALL be discarded, decrementing drop_cnt.
REQ-024 Redirect during id_valid && id_ready: that instruction SHALL count as delivered; all other FIFO entries discarded.
REQ-025 Redirect and response in the same cycle: response SHALL be discarded.
REQ-026 FIFO pop on id_valid && id_ready; simultaneous push and pop SHALL keep count unchanged; overflow impossible by REQ-018.
REQ-027 id_* SHALL hold stable while id_valid && !id_ready.
REQ-028 PC of each entry SHALL be tracked in a request-order address queue sharing the FIFO credit.

Reset
REQ-029 On reset: PC = RESET_PC, outstanding = 0, drop_cnt = 0, FIFO empty.
REQ-030 On reset: imem_req_valid = 0, id_valid = 0, id_illegal = 0, id_instr = 0, id_pc = 0, id_opcode = 0.
REQ-031 Reset SHALL take priority over redirect and response; imem shares the same reset so no pre-reset response arrives after it.
REQ-032 First request SHALL issue in the first cycle after reset deasserts, address RESET_PC.

Configuration
REQ-033 Macro FETCH_ILLEGAL_CHECK_EN defined: id_illegal = 1 when id_opcode is none of 0110011, 0000011, 0100011, 0010011, 1100011; undefined: id_illegal tied 0 and no check logic.

Structure
REQ-034 Package fetch_pkg SHALL hold opcode constants (OPC_RTYPE, OPC_LOAD, OPC_STORE, OPC_ITYPE, OPC_BRANCH), shared with the control unit, plus the fetch-entry struct {instr, pc}.
REQ-035 Buffer SHALL be sub-module fetch_fifo (parameterised depth, synchronous flush input).

Verification
REQ-036 Reset release, imem_req_ready = 1, 1-cycle memory, id_ready = 1 -> addresses 0,4,8,... one per cycle; id_pc matches id_instr order.
REQ-037 id_ready = 0 for 10 cycles -> exactly 4 requests issue, then imem_req_valid = 0; id_* stable; release drains 0,4,8,C.
REQ-038 Two requests outstanding (0x10, 0x14), redirect to 0x203 -> both responses dropped; next id_pc = 0x200.
REQ-039 Redirect in same cycle as response and id handshake -> handshaken instruction delivered once, response discarded, FIFO empty.
REQ-040 RESET_PC = 32'hFFFF_FFF8 -> fetches FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-041 With FETCH_ILLEGAL_CHECK_EN, response 32'h0000_007F -> id_illegal = 1; 32'h0000_0033 -> 0; without the macro both -> 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Fetch/decode shared definitions: RV32 opcode constants, the instruction
// buffer entry, and the opcode recognition helper used by the decode check.
package fetch_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic opcode_known(input logic [6:0] opc);
        return (opc == OPC_RTYPE) || (opc == OPC_LOAD) || (opc == OPC_STORE) ||
               (opc == OPC_ITYPE) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two circular buffer with synchronous flush; head is read
// combinationally so a pushed entry is visible the cycle after the push.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i && !rst_i) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, in-order imem request/response tracking, redirect
// squash and decode buffer. Define FETCH_ILLEGAL_CHECK_EN to flag unknown opcodes.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [6:0]  id_opcode,
    output logic        id_illegal
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outst_q, outst_d, drop_q, drop_d;
    logic [CW-1:0] buf_cnt;
    logic          buf_empty, req_fire, rsp_keep, id_fire;
    logic [31:0]   rsp_pc;
    fetch_entry_t  push_entry, head;

    logic          unused_aq_empty, unused_rpc_bits;
    logic [CW-1:0] unused_aq_cnt;

    // In-flight requests plus buffered instructions never exceed the buffer,
    // so every response always has a slot waiting for it.
    assign imem_req_valid = !reset && !redirect_valid &&
                            (({1'b0, outst_q} + {1'b0, buf_cnt}) < DEPTH_W);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && !redirect_valid && (drop_q == '0);
    assign id_fire        = id_valid && id_ready;

    always_comb begin
        pc_d    = pc_q;
        drop_d  = drop_q;
        outst_d = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
        if (req_fire) pc_d = pc_q + 32'd4;
        if (redirect_valid) begin
            pc_d   = {redirect_pc[31:2], 2'b00};
            drop_d = outst_q - CW'(imem_rsp_valid);
        end else if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    // Request-order address queue: popped only by responses that survive,
    // emptied on redirect since every older response will be dropped.
    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_addr_q (
        .clk_i   (clk),
        .rst_i   (reset),
        .flush_i (redirect_valid),
        .push_i  (req_fire),
        .data_i  (pc_q),
        .pop_i   (rsp_keep),
        .data_o  (rsp_pc),
        .empty_o (unused_aq_empty),
        .count_o (unused_aq_cnt)
    );

    assign push_entry = '{instr: imem_rsp_data, pc: rsp_pc};

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fetch_entry_t))) u_ibuf (
        .clk_i   (clk),
        .rst_i   (reset),
        .flush_i (redirect_valid),
        .push_i  (rsp_keep),
        .data_i  (push_entry),
        .pop_i   (id_fire),
        .data_o  (head),
        .empty_o (buf_empty),
        .count_o (buf_cnt)
    );

    assign id_valid  = !buf_empty;
    assign id_instr  = id_valid ? head.instr : '0;
    assign id_pc     = id_valid ? head.pc    : '0;
    assign id_opcode = id_instr[6:0];

`ifdef FETCH_ILLEGAL_CHECK_EN
    assign id_illegal = id_valid && !opcode_known(id_opcode);
`else
    assign id_illegal = 1'b0;
`endif

    assign unused_rpc_bits = ^redirect_pc[1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against a stream-level model: delivered PCs
// run consecutively from the last reset/redirect, imem replies in order.
module tb_fetch_unit;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_ILLEGAL_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic        redirect_valid, id_valid, id_ready, id_illegal;
    logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, id_instr, id_pc;
    logic [6:0]  id_opcode;

    logic        r2_reset, r2_req_valid, r2_rsp_valid, r2_id_valid, r2_id_illegal;
    logic [31:0] r2_req_addr, r2_rsp_data, r2_id_instr, r2_id_pc;
    logic [6:0]  r2_id_opcode;

    fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc), .id_opcode(id_opcode),
        .id_illegal(id_illegal)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .reset(r2_reset),
        .imem_req_valid(r2_req_valid), .imem_req_ready(1'b1),
        .imem_req_addr(r2_req_addr), .imem_rsp_valid(r2_rsp_valid),
        .imem_rsp_data(r2_rsp_data), .redirect_valid(1'b0),
        .redirect_pc(32'h0), .id_valid(r2_id_valid), .id_ready(1'b1),
        .id_instr(r2_id_instr), .id_pc(r2_id_pc), .id_opcode(r2_id_opcode),
        .id_illegal(r2_id_illegal)
    );

    typedef struct { logic [31:0] addr; int due; int epoch; } mreq_t;

    mreq_t       pend[$];
    logic [31:0] dq[$];
    int          cyc, epoch, mbuf, lat_lo, lat_hi, n_acc;
    logic [31:0] exp_req_pc, exp_id_pc;
    int          n_checks, n_fail;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h300) return 32'h0000_007F;
        if (a == 32'h304) return 32'h0000_0033;
        return {a[26:2], 7'b0010011};
    endfunction

    function automatic bit exp_illegal(input logic [31:0] w);
        logic [6:0] o;
        o = w[6:0];
        return CHK_EN && !(o == 7'h33 || o == 7'h03 || o == 7'h23 || o == 7'h13 || o == 7'h63);
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0; id_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_id_valid",  32'(id_valid),       32'd0);
        check("rst_id_pc",     id_pc,               32'd0);
        check("rst_id_instr",  id_instr,            32'd0);
        check("rst_id_opcode", 32'(id_opcode),      32'd0);
        check("rst_id_illegal", 32'(id_illegal),    32'd0);
        reset = 1'b0;
        pend.delete(); dq.delete();
        mbuf = 0; n_acc = 0; epoch++;
        exp_req_pc = RST_PC; exp_id_pc = RST_PC;
    endtask

    task automatic cycle(input bit rdr, input logic [31:0] rpc, input bit rdy, input bit idr);
        bit    fire, kept, acc;
        mreq_t e;
        @(negedge clk);
        imem_req_ready = rdy; id_ready = idr; redirect_valid = rdr; redirect_pc = rpc;
        fire = (pend.size() > 0) && (pend[0].due <= cyc);
        imem_rsp_valid = fire;
        imem_rsp_data  = fire ? mem_word(pend[0].addr) : $urandom;
        #1;
        check("req_valid", 32'(imem_req_valid), 32'(!rdr && ((pend.size() + mbuf) < DEPTH)));
        if (imem_req_valid) check("req_addr", imem_req_addr, exp_req_pc);
        check("id_valid", 32'(id_valid), 32'(mbuf > 0));
        if (mbuf > 0) begin
            check("id_pc",      id_pc,           exp_id_pc);
            check("id_instr",   id_instr,        mem_word(exp_id_pc));
            check("id_opcode",  32'(id_opcode),  mem_word(exp_id_pc) & 32'h7F);
            check("id_illegal", 32'(id_illegal), 32'(exp_illegal(mem_word(exp_id_pc))));
        end else begin
            check("id_illegal_idle", 32'(id_illegal), 32'd0);
        end
        acc  = imem_req_valid && rdy;
        kept = 1'b0;
        if (fire) begin
            e    = pend.pop_front();
            kept = (e.epoch == epoch) && !rdr;
        end
        if (id_valid && idr) dq.push_back(id_pc);
        if (mbuf > 0 && idr) begin
            mbuf--;
            exp_id_pc += 32'd4;
        end
        if (kept) mbuf++;
        if (acc) begin
            pend.push_back('{imem_req_addr, cyc + int'($urandom_range(lat_hi, lat_lo)), epoch});
            n_acc++;
            exp_req_pc += 32'd4;
        end
        if (rdr) begin
            epoch++;
            mbuf       = 0;
            exp_req_pc = {rpc[31:2], 2'b00};
            exp_id_pc  = exp_req_pc;
        end
        cyc++;
    endtask

    initial begin
        bit          rd, rr, ir;
        bit          p2;
        logic [31:0] pa2;
        logic [31:0] a2[$];
        logic [31:0] d2[$];

        n_checks = 0; n_fail = 0; cyc = 0; epoch = 0; mbuf = 0; n_acc = 0;
        lat_lo = 1; lat_hi = 1;
        reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        r2_reset = 1'b1; r2_rsp_valid = 1'b0; r2_rsp_data = '0;

        // Streaming, one fetch per cycle
        do_reset();
        repeat (12) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("seq_pc0", q_at(dq, 0), 32'h0);
        check("seq_pc1", q_at(dq, 1), 32'h4);
        check("seq_pc2", q_at(dq, 2), 32'h8);

        // Decode stall fills the buffer then request issue stops
        do_reset();
        repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("stall_reqs", n_acc, 32'd4);
        repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("drain_pc0", q_at(dq, 0), 32'h0);
        check("drain_pc1", q_at(dq, 1), 32'h4);
        check("drain_pc2", q_at(dq, 2), 32'h8);
        check("drain_pc3", q_at(dq, 3), 32'hC);

        // Redirect with two requests in flight
        do_reset();
        lat_lo = 4; lat_hi = 4;
        cycle(1'b1, 32'h10, 1'b1, 1'b1);
        repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("two_inflight", n_acc, 32'd2);
        lat_lo = 1; lat_hi = 1;
        dq.delete();
        cycle(1'b1, 32'h203, 1'b1, 1'b1);
        repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("redir_first_pc", q_at(dq, 0), 32'h200);

        // Redirect coinciding with a response and a decode handshake
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("pre_redir_rsp", 32'(pend.size() > 0 && mbuf > 0), 32'd1);
        cycle(1'b1, 32'h300, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("flush_empty", 32'(id_valid), 32'd0);
        dq.delete();
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("illegal_seq_pc", q_at(dq, 0), 32'h300);

        // PC wrap across the top of the address space
        cycle(1'b1, 32'hFFFF_FFF1, 1'b1, 1'b1);
        repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b1);

        // Randomised traffic
        do_reset();
        lat_lo = 1; lat_hi = 3;
        for (int i = 0; i < 2000; i++) begin
            rd = ($urandom_range(99) < 3);
            rr = ($urandom_range(99) < 70);
            ir = ($urandom_range(99) < 60);
            cycle(rd, $urandom, rr, ir);
        end

        // Wrapping reset PC on the second instance, ideal memory and decode
        p2 = 1'b0; pa2 = '0;
        repeat (2) @(posedge clk);
        #1;
        r2_reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            r2_rsp_valid = p2;
            r2_rsp_data  = mem_word(pa2);
            #1;
            if (r2_req_valid) a2.push_back(r2_req_addr);
            if (r2_id_valid)  d2.push_back(r2_id_pc);
            p2  = r2_req_valid;
            pa2 = r2_req_addr;
        end
        check("wrap_req0", q_at(a2, 0), 32'hFFFF_FFF8);
        check("wrap_req1", q_at(a2, 1), 32'hFFFF_FFFC);
        check("wrap_req2", q_at(a2, 2), 32'h0000_0000);
        check("wrap_id0",  q_at(d2, 0), 32'hFFFF_FFF8);
        check("wrap_id1",  q_at(d2, 1), 32'hFFFF_FFFC);
        check("wrap_id2",  q_at(d2, 2), 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
